// File: rtl/phy_rx_pkg.sv
// Shared types and defaults for the multi-lane serial receiver.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } lane_state_e;

    localparam logic [7:0] DEF_COMMA      = 8'hBC;
    localparam int         DEF_SYNC_COUNT = 4;

endpackage

// File: rtl/phy_rx_lane.sv
// One serial lane: comma alignment FSM, byte framing, word packing into a holding register.
module phy_rx_lane
    import phy_rx_pkg::*;
#(
    parameter int         WORD_W     = 32,
    parameter int         SYNC_COUNT = DEF_SYNC_COUNT,
    parameter logic [7:0] COMMA      = DEF_COMMA
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              din,
    input  logic              consume,
    output logic              active,
    output logic              full,
    output logic              drop,
    output logic [WORD_W-1:0] hold
);

    localparam int             NB        = WORD_W / 8;
    localparam int             BCW       = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
    localparam logic [3:0]     SYNC_N    = 4'(SYNC_COUNT);

    lane_state_e       state_q, state_d;
    logic [7:0]        shift_q, shift_d, cand;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        comma_cnt_q, comma_cnt_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] word_q, word_d, word_nxt, hold_q, hold_d;
    logic              full_q, full_d, complete;

    assign cand     = {shift_q[6:0], din};
    assign word_nxt = (word_q << 8) | WORD_W'(cand);
    assign active   = (state_q == ST_ACTIVE);
    assign full     = full_q;
    assign hold     = hold_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = cand;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        hold_d      = hold_q;
        full_d      = full_q;
        complete    = 1'b0;
        drop        = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                byte_cnt_d = '0;
                word_d     = '0;
                // Bit-sliding: any comma hit defines the byte boundary.
                if (cand == COMMA) begin
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 4'd1;
                    state_d     = (SYNC_N == 4'd1) ? ST_ACTIVE : ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (bit_cnt_q == 3'd7) begin
                    if (cand == COMMA) begin
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        if (comma_cnt_q + 4'd1 == SYNC_N) state_d = ST_ACTIVE;
                    end else begin
                        comma_cnt_d = 4'd0;
                        state_d     = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                if (bit_cnt_q == 3'd7 && cand != COMMA) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        complete   = 1'b1;
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        word_d     = word_nxt;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        // A finished word is lost only if the old one is still unclaimed.
        if (complete) begin
            if (full_q && !consume) begin
                drop = 1'b1;
            end else begin
                hold_d = word_nxt;
                full_d = 1'b1;
            end
        end else if (consume) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_SEARCH;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
        end
    end

endmodule

// File: rtl/phy_rx_nlane.sv
// N-lane serial receiver: per-lane alignment plus a strict round-robin unstriper.
module phy_rx_nlane
    import phy_rx_pkg::*;
#(
    parameter int         LANES      = 2,
    parameter int         WORD_W     = 32,
    parameter int         SYNC_COUNT = DEF_SYNC_COUNT,
    parameter logic [7:0] COMMA      = DEF_COMMA
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [LANES-1:0]  data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic [LANES-1:0]  active,
    output logic              active_all,
    output logic              overflow
);

    localparam int RRW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]             full, drop, consume;
    logic [LANES-1:0][WORD_W-1:0] hold;
    logic [RRW-1:0]               rr_q, rr_d;
    logic [WORD_W-1:0]            data_out_q, data_out_d;
    logic                         valid_out_q, valid_out_d;
    logic                         overflow_q, overflow_d;
    logic                         take;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        phy_rx_lane #(
            .WORD_W    (WORD_W),
            .SYNC_COUNT(SYNC_COUNT),
            .COMMA     (COMMA)
        ) u_lane (
            .clk    (clk),
            .reset_L(reset_L),
            .din    (data_in[l]),
            .consume(consume[l]),
            .active (active[l]),
            .full   (full[l]),
            .drop   (drop[l]),
            .hold   (hold[l])
        );
        assign consume[l] = take && (rr_q == RRW'(l));
    end

    assign active_all = &active;
    // rr never skips: an empty lane stalls output even if others are full.
    assign take       = active_all && full[rr_q];

    always_comb begin
        rr_d        = rr_q;
        data_out_d  = data_out_q;
        valid_out_d = take;
        overflow_d  = overflow_q | (|drop);
        if (take) begin
            data_out_d = hold[rr_q];
            rr_d       = (rr_q == RRW'(LANES - 1)) ? '0 : rr_q + RRW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_q        <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_phy_rx_nlane.sv
// Scoreboard bench for phy_rx_nlane: per-lane bit queues feed the DUT, a monitor checks words.
module tb_phy_rx_nlane;

    localparam int LANES  = 2;
    localparam int WORD_W = 32;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic [LANES-1:0]  data_in = '0;
    logic [WORD_W-1:0] data_out;
    logic              valid_out;
    logic [LANES-1:0]  active;
    logic              active_all;
    logic              overflow;

    bit                bq[LANES][$];
    logic [WORD_W-1:0] exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                n_valid = 0;

    phy_rx_nlane #(.LANES(LANES), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .active_all(active_all),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Serial driver: one bit per lane per cycle, zero when a lane has nothing queued.
    always @(negedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (bq[l].size() > 0) data_in[l] = bq[l].pop_front();
            else                  data_in[l] = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: every presented word must be the next one the model predicted.
    always @(negedge clk) begin
        if (reset_L === 1'b1 && valid_out === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", data_out);
            end else begin
                chk("word", {32'h0, data_out}, {32'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_byte(input int l, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bq[l].push_back(b[i]);
    endtask

    task automatic push_commas(input int l, input int n);
        for (int i = 0; i < n; i++) push_byte(l, 8'hBC);
    endtask

    task automatic push_word(input int l, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) push_byte(l, w[i*8 +: 8]);
    endtask

    task automatic drain();
        int n = 0;
        while ((bq[0].size() > 0 || bq[1].size() > 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 5000) chk("drain_timeout", 64'(n), 64'(0));
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        for (int l = 0; l < LANES; l++) bq[l].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 reset_L = 1'b1;
    endtask

    function automatic logic [7:0] rnd_data();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == 8'hBC);
        return b;
    endfunction

    initial begin
        int v0;
        logic [31:0] w [LANES];
        int slot;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_out), 0);
        chk("rst_data", 64'(data_out), 0);
        chk("rst_active", 64'(active), 0);
        chk("rst_active_all", 64'(active_all), 0);
        chk("rst_overflow", 64'(overflow), 0);
        #1 reset_L = 1'b1;

        // basic bring-up: 4 commas then one word per lane
        for (int l = 0; l < LANES; l++) push_commas(l, 3);
        drain();
        chk("active_after_3_commas", 64'(active), 0);
        for (int l = 0; l < LANES; l++) push_commas(l, 1);
        drain();
        chk("active_after_4_commas", 64'(active), 64'(2'b11));
        chk("active_all_up", 64'(active_all), 1);
        v0 = n_valid;
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'h05060708);
        push_word(0, 32'h01020304);
        push_word(1, 32'h05060708);
        for (int l = 0; l < LANES; l++) push_commas(l, 2);
        drain();
        chk("basic_words_seen", 64'(n_valid - v0), 2);
        chk("basic_queue_empty", 64'(exp_q.size()), 0);

        // lane 1 skewed by 3 bits: order must still be lane0 then lane1
        apply_reset();
        repeat (3) bq[1].push_back(1'b0);
        for (int l = 0; l < LANES; l++) push_commas(l, 4);
        exp_q.push_back(32'hAABBCCDD);
        exp_q.push_back(32'h11223344);
        push_word(0, 32'hAABBCCDD);
        push_word(1, 32'h11223344);
        for (int l = 0; l < LANES; l++) push_commas(l, 2);
        drain();
        chk("skew_queue_empty", 64'(exp_q.size()), 0);

        // comma count is cleared by a non-comma during SYNC
        apply_reset();
        push_commas(0, 2);
        push_byte(0, 8'h55);
        push_commas(0, 3);
        drain();
        chk("sync_reset_not_active", 64'(active[0]), 0);
        push_commas(0, 1);
        drain();
        chk("sync_reset_active", 64'(active[0]), 1);

        // lane 1 silent: no output, second word overflows
        apply_reset();
        v0 = n_valid;
        push_commas(0, 4);
        push_word(0, 32'hDEADBEEF);
        push_commas(0, 1);
        drain();
        chk("ovf_after_first", 64'(overflow), 0);
        push_word(0, 32'h12345678);
        push_commas(0, 1);
        drain();
        chk("ovf_after_second", 64'(overflow), 1);
        chk("ovf_active", 64'(active), 64'(2'b01));
        chk("ovf_no_valid", 64'(n_valid - v0), 0);

        // idle commas interleaved with data are discarded
        apply_reset();
        for (int l = 0; l < LANES; l++) push_commas(l, 4);
        push_byte(0, 8'h12); push_byte(0, 8'hBC); push_byte(0, 8'h34);
        push_byte(0, 8'h56); push_byte(0, 8'h78);
        push_byte(1, 8'h9A); push_byte(1, 8'hBC); push_byte(1, 8'hDE);
        push_byte(1, 8'hAD); push_byte(1, 8'hBE);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h9ADEADBE);
        for (int l = 0; l < LANES; l++) push_commas(l, 2);
        drain();
        chk("idle_queue_empty", 64'(exp_q.size()), 0);

        // randomized: random skew, 6 words per lane, one idle comma at a random slot
        apply_reset();
        for (int l = 0; l < LANES; l++) begin
            repeat ($urandom_range(0, 7)) bq[l].push_back(1'b0);
            push_commas(l, 4);
        end
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < 4; b++) w[l][(3-b)*8 +: 8] = rnd_data();
                exp_q.push_back(w[l]);
                slot = $urandom_range(0, 4);
                for (int s = 0, b = 3; s < 5; s++) begin
                    if (s == slot) push_byte(l, 8'hBC);
                    else begin
                        push_byte(l, w[l][b*8 +: 8]);
                        b--;
                    end
                end
            end
        end
        for (int l = 0; l < LANES; l++) push_commas(l, 2);
        drain();
        chk("rand_queue_empty", 64'(exp_q.size()), 0);
        chk("rand_no_overflow", 64'(overflow), 0);

        // async reset mid-word, then resync needed
        apply_reset();
        for (int l = 0; l < LANES; l++) push_commas(l, 4);
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h0BADBEEF);
        push_word(0, 32'hCAFEF00D);
        push_word(1, 32'h0BADBEEF);
        for (int l = 0; l < LANES; l++) push_commas(l, 2);
        push_byte(0, 8'h11); push_byte(0, 8'h22);
        push_byte(1, 8'h33); push_byte(1, 8'h44);
        drain();
        chk("pre_rst_data", 64'(data_out), 64'(32'h0BADBEEF));
        #2 reset_L = 1'b0;
        #1;
        chk("async_rst_data", 64'(data_out), 0);
        chk("async_rst_valid", 64'(valid_out), 0);
        chk("async_rst_active", 64'(active), 0);
        chk("async_rst_active_all", 64'(active_all), 0);
        chk("async_rst_overflow", 64'(overflow), 0);
        for (int l = 0; l < LANES; l++) bq[l].delete();
        repeat (2) @(posedge clk);
        #2 reset_L = 1'b1;
        v0 = n_valid;
        for (int l = 0; l < LANES; l++) begin
            push_commas(l, 3);
            push_word(l, 32'h00010203);
        end
        drain();
        chk("resync_not_active", 64'(active), 0);
        chk("resync_no_valid", 64'(n_valid - v0), 0);
        for (int l = 0; l < LANES; l++) push_commas(l, 4);
        exp_q.push_back(32'hA1A2A3A4);
        exp_q.push_back(32'hB1B2B3B4);
        push_word(0, 32'hA1A2A3A4);
        push_word(1, 32'hB1B2B3B4);
        for (int l = 0; l < LANES; l++) push_commas(l, 2);
        drain();
        chk("resync_queue_empty", 64'(exp_q.size()), 0);
        chk("resync_words_seen", 64'(n_valid - v0), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
